rcn_sram_slave: RTL and testbench



---
 rtl/rcn_pkg.sv | 28 ++
 rtl/rcn_sram_slave.sv | 95 +++++++++
 tb/tb_rcn_sram_slave.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/rcn_pkg.sv
// Shared RCN ring definitions: 69-bit slot layout and the address-window hit helper.
package rcn_pkg;

  localparam int RCN_W        = 69;
  localparam int RCN_VALID    = 68;
  localparam int RCN_PENDING  = 67;
  localparam int RCN_WR       = 66;
  localparam int RCN_ID_LSB   = 60;
  localparam int RCN_ID_W     = 6;
  localparam int RCN_MASK_LSB = 56;
  localparam int RCN_MASK_W   = 4;
  localparam int RCN_ADDR_LSB = 34;
  localparam int RCN_ADDR_W   = 22;
  localparam int RCN_SEQ_LSB  = 32;
  localparam int RCN_SEQ_W    = 2;
  localparam int RCN_DATA_LSB = 0;
  localparam int RCN_DATA_W   = 32;

  // A slot is a hit when it is a live request whose byte address lands in the window.
  function automatic logic rcn_hit(input logic [RCN_W-1:0] slot,
                                   input logic [23:0]      win_mask,
                                   input logic [23:0]      win_base);
    logic [23:0] byte_addr;
    byte_addr = {slot[RCN_ADDR_LSB +: RCN_ADDR_W], 2'b00};
    return slot[RCN_VALID] & slot[RCN_PENDING] & ((byte_addr & win_mask) == win_base);
  endfunction

endpackage

// File: rtl/rcn_sram_slave.sv
// RCN ring responder: claims in-window requests, performs one SRAM access and
// returns the response in the same slot two cycles later.
module rcn_sram_slave
  import rcn_pkg::*;
#(
  parameter logic [23:0] ADDR_MASK = 24'hFF0000,
  parameter logic [23:0] ADDR_BASE = 24'h010000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RCN_W-1:0]  rcn_in,
  output logic [RCN_W-1:0]  rcn_out,
  output logic              cs,
  output logic              wr,
  output logic [23:0]       addr,
  output logic [3:0]        mask,
  output logic [31:0]       wdata,
  input  logic [31:0]       rdata,
  input  logic              rdy,
  output logic [15:0]       retry_cnt
);

  logic [RCN_W-1:0] rin_r;
  logic [RCN_W-1:0] rout_r;
  logic             rd_resp_r;
  logic [15:0]      retry_cnt_r;

  logic             hit_s;
  logic             claim_s;
  logic             defer_s;
  logic [RCN_W-1:0] rout_next_s;

  // Per-slot decision: claim on hit with rdy, otherwise defer or pass through.
  always_comb begin
    hit_s       = rcn_hit(rin_r, ADDR_MASK, ADDR_BASE);
    claim_s     = hit_s & rdy;
    defer_s     = hit_s & ~rdy;
    rout_next_s = rin_r;
    if (claim_s) begin
      rout_next_s[RCN_PENDING] = 1'b0;
    end else begin
      rout_next_s[RCN_PENDING] = rin_r[RCN_PENDING];
    end
  end

  // Memory port is driven straight from stage A so the access lands at N+1.
  assign cs    = claim_s;
  assign wr    = rin_r[RCN_WR];
  assign addr  = {rin_r[RCN_ADDR_LSB +: RCN_ADDR_W], 2'b00};
  assign mask  = rin_r[RCN_MASK_LSB +: RCN_MASK_W];
  assign wdata = rin_r[RCN_DATA_LSB +: RCN_DATA_W];

  // Stage A: capture the incoming ring slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rin_r <= {RCN_W{1'b0}};
    end else begin
      rin_r <= rcn_in;
    end
  end

  // Stage B: slot with claim applied, plus flag to splice read data in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rout_r    <= {RCN_W{1'b0}};
      rd_resp_r <= 1'b0;
    end else begin
      rout_r    <= rout_next_s;
      rd_resp_r <= claim_s & ~rin_r[RCN_WR];
    end
  end

  // Saturating count of requests bounced because the memory was not ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retry_cnt_r <= 16'h0000;
    end else if (defer_s && (retry_cnt_r != 16'hFFFF)) begin
      retry_cnt_r <= retry_cnt_r + 16'h0001;
    end else begin
      retry_cnt_r <= retry_cnt_r;
    end
  end

  // Read data arrives one cycle after cs, so it is merged combinationally here.
  always_comb begin
    if (rd_resp_r) begin
      rcn_out = {rout_r[RCN_W-1:RCN_SEQ_LSB], rdata};
    end else begin
      rcn_out = rout_r;
    end
  end

  assign retry_cnt = retry_cnt_r;

endmodule

// File: tb/tb_rcn_sram_slave.sv
// Self-checking bench for rcn_sram_slave: directed cases then random slots,
// compared against a slot-level reference model.
module tb_rcn_sram_slave;

  logic        clk;
  logic        rst;
  logic [68:0] rcn_in;
  logic [68:0] rcn_out;
  logic        cs;
  logic        wr;
  logic [23:0] addr;
  logic [3:0]  mask;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rdy;
  logic [15:0] retry_cnt;

  int n_cmp;
  int n_bad;

  // Model history: the two most recent slots and the rdy each one saw.
  logic [68:0] prev_s;
  logic [68:0] prev2_s;
  bit          prev_y;
  bit          prev2_y;
  int          exp_retry;

  rcn_sram_slave dut (
    .clk       (clk),
    .rst       (rst),
    .rcn_in    (rcn_in),
    .rcn_out   (rcn_out),
    .cs        (cs),
    .wr        (wr),
    .addr      (addr),
    .mask      (mask),
    .wdata     (wdata),
    .rdata     (rdata),
    .rdy       (rdy),
    .retry_cnt (retry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [68:0] obs, input logic [68:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [68:0] mk(input bit w, input logic [5:0] id, input logic [1:0] seq,
                                     input logic [23:0] a, input logic [3:0] m, input logic [31:0] d);
    return {1'b1, 1'b1, w, id, m, a[23:2], seq, d};
  endfunction

  // Window for default parameters is byte addresses 0x010000..0x01FFFF.
  function automatic bit m_hit(input logic [68:0] s);
    int unsigned a;
    a = {8'h00, s[55:34], 2'b00};
    return s[68] && s[67] && (a >= 32'h0001_0000) && (a <= 32'h0001_FFFF);
  endfunction

  function automatic logic [68:0] m_resp(input logic [68:0] s, input bit y, input logic [31:0] d);
    logic [68:0] r;
    r = s;
    if (m_hit(s) && y) begin
      r[67] = 1'b0;
      if (!s[66]) r[31:0] = d;
    end
    return r;
  endfunction

  // One ring cycle: offer slot s (with the rdy it will see next cycle) and check outputs.
  task automatic step(input logic [68:0] s, input bit y, input logic [31:0] d);
    bit ecs;
    @(negedge clk);
    rcn_in = s;
    rdy    = prev_y;
    rdata  = d;
    #1;
    ecs = m_hit(prev_s) && prev_y;
    chk("cs", {68'd0, cs}, {68'd0, ecs});
    if (ecs) begin
      chk("wr",    {68'd0, wr},     {68'd0, prev_s[66]});
      chk("addr",  {45'd0, addr},   {45'd0, prev_s[55:34], 2'b00});
      chk("mask",  {65'd0, mask},   {65'd0, prev_s[59:56]});
      chk("wdata", {37'd0, wdata},  {37'd0, prev_s[31:0]});
    end
    chk("rcn_out", rcn_out, m_resp(prev2_s, prev2_y, d));
    chk("retry_cnt", {53'd0, retry_cnt}, 69'(exp_retry));
    if (m_hit(prev_s) && !prev_y && exp_retry < 65535) exp_retry++;
    prev2_s = prev_s;
    prev2_y = prev_y;
    prev_s  = s;
    prev_y  = y;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(69'd0, 1'b0, $urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b1;
    rcn_in = 69'd0;
    #1;
    chk("rst_rcn_out", rcn_out, 69'd0);
    chk("rst_cs", {68'd0, cs}, 69'd0);
    chk("rst_retry", {53'd0, retry_cnt}, 69'd0);
    @(negedge clk);
    rst       = 1'b0;
    prev_s    = 69'd0;
    prev2_s   = 69'd0;
    prev_y    = 1'b0;
    prev2_y   = 1'b0;
    exp_retry = 0;
  endtask

  initial begin
    logic [68:0] s;
    logic [23:0] a;
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; rcn_in = 69'd0; rdata = 32'd0; rdy = 1'b0;
    prev_s = 69'd0; prev2_s = 69'd0; prev_y = 1'b0; prev2_y = 1'b0; exp_retry = 0;
    repeat (2) @(posedge clk);
    do_reset();

    // Read hit with fixed read data at response time.
    step(mk(1'b0, 6'd5, 2'd2, 24'h010040, 4'hF, 32'h0), 1'b1, $urandom);
    step(69'd0, 1'b0, $urandom);
    step(69'd0, 1'b0, 32'hDEADBEEF);
    // Write hit at top of window.
    step(mk(1'b1, 6'd9, 2'd1, 24'h01FFFC, 4'h3, 32'h12345678), 1'b1, $urandom);
    idle(2);
    // Miss: other window, then a response slot inside the window.
    step(mk(1'b0, 6'd1, 2'd0, 24'h020000, 4'hF, 32'h11112222), 1'b1, $urandom);
    s = mk(1'b0, 6'd2, 2'd3, 24'h010100, 4'h0, 32'hCAFEF00D);
    s[67] = 1'b0;
    step(s, 1'b1, $urandom);
    idle(2);
    // Deferral three times, then claimed on the fourth pass.
    s = mk(1'b0, 6'd7, 2'd1, 24'h010800, 4'hF, 32'h0);
    step(s, 1'b0, $urandom);
    step(s, 1'b0, $urandom);
    step(s, 1'b0, $urandom);
    step(s, 1'b1, $urandom);
    idle(2);
    chk("retry_after_defer", 69'(exp_retry), 69'd3);
    // Back-to-back R,W,R,W with zero mask on one of them.
    step(mk(1'b0, 6'd10, 2'd0, 24'h010004, 4'hF, 32'h0),        1'b1, $urandom);
    step(mk(1'b1, 6'd11, 2'd1, 24'h010008, 4'h0, 32'hA5A5A5A5), 1'b1, $urandom);
    step(mk(1'b0, 6'd12, 2'd2, 24'h01000C, 4'h1, 32'h0),        1'b1, $urandom);
    step(mk(1'b1, 6'd13, 2'd3, 24'h010010, 4'h8, 32'h5A5A5A5A), 1'b1, $urandom);
    // Reset mid-stream with slots in flight.
    do_reset();
    idle(2);

    // Random mix of hits, misses, responses, empty slots and rdy.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(1, 0) == 1) a = {8'h01, 16'($urandom)};
      else                           a = 24'($urandom);
      s = mk(1'($urandom), 6'($urandom), 2'($urandom), a, 4'($urandom), $urandom);
      s[68] = ($urandom_range(7, 0) != 0);
      s[67] = ($urandom_range(3, 0) != 0);
      step(s, 1'($urandom), $urandom);
      if (i == 200) begin
        do_reset();
      end
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
